// File: rtl/reloj_pkg.sv
// reloj_pkg: shared widths and digit limits for the time-of-day generator.
//   BCD_W          width of one BCD digit
//   DIG_MAX        largest decimal digit value (units wrap point)
//   MIN_U_MAX ..   per-digit limits for HH:MM
//   SEG_W/SEG_MAX  internal seconds counter width and terminal value
package reloj_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] DIG_MAX       = 4'd9;
    localparam logic [BCD_W-1:0] MIN_U_MAX     = 4'd9;
    localparam logic [BCD_W-1:0] MIN_D_MAX     = 4'd5;
    localparam logic [BCD_W-1:0] HORA_D_MAX    = 4'd2;
    localparam logic [BCD_W-1:0] HORA_U_MAX_23 = 4'd3;

    localparam int             SEG_W   = 6;
    localparam logic [SEG_W-1:0] SEG_MAX = 6'd59;

    // True when a two-digit BCD value lies inside 00..{dmax}{umax}.
    function automatic logic bcd2_legal(input logic [BCD_W-1:0] dec,
                                        input logic [BCD_W-1:0] uni,
                                        input logic [BCD_W-1:0] dmax,
                                        input logic [BCD_W-1:0] umax);
        logic ok;
        ok = (dec <= dmax) && (uni <= DIG_MAX);
        if (dec == dmax && uni > umax)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/contador_bcd2.sv
// contador_bcd2: two-digit BCD counter 00..{DEC_MAX}{UNI_TOP}.
//   reloj1   clock
//   reset_n  async active-low reset, clears to 00
//   clr      synchronous clear to 00
//   en       advance by one this cycle
//   uni/dec  registered units / tens digits
//   carry    combinational: en while at the terminal value (wraps this edge)
// The units digit wraps at 9 except when the tens digit sits at DEC_MAX,
// where it wraps at UNI_TOP (this is what gives 23 -> 00 for hours).
module contador_bcd2
    import reloj_pkg::*;
#(
    parameter logic [BCD_W-1:0] DEC_MAX = MIN_D_MAX,
    parameter logic [BCD_W-1:0] UNI_TOP = MIN_U_MAX
) (
    input  logic             reloj1,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] uni,
    output logic [BCD_W-1:0] dec,
    output logic             carry
);

    logic at_top;
    logic legal;

    always_comb begin
        at_top = (dec == DEC_MAX) && (uni == UNI_TOP);
        legal  = bcd2_legal(dec, uni, DEC_MAX, UNI_TOP);
        carry  = en && at_top;
    end

    always_ff @(posedge reloj1 or negedge reset_n) begin
        if (!reset_n) begin
            uni <= '0;
            dec <= '0;
        end else if (clr) begin
            uni <= '0;
            dec <= '0;
        end else if (en) begin
            // A fault-only illegal value is folded back to 00 without carry.
            if (at_top || !legal) begin
                uni <= '0;
                dec <= '0;
            end else if (uni == DIG_MAX) begin
                uni <= '0;
                dec <= dec + 4'd1;
            end else begin
                uni <= uni + 4'd1;
            end
        end
    end

endmodule

// File: rtl/reloj_hora.sv
// reloj_hora: 1 Hz time-of-day generator, 24 h HH:MM in BCD.
//   reloj1   clock (CLK_HZ cycles per second)
//   reset_n  async active-low reset
//   ajuste   set mode level; inc_h / inc_m add hours / minutes on rising edge
//   b0..b3   minutes units, minutes tens, hours units, hours tens
//   seg      one-cycle pulse per elapsed second (run mode only)
//   minuto   one-cycle pulse on the automatic minute advance
module reloj_hora
    import reloj_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic             reloj1,
    input  logic             reset_n,
    input  logic             ajuste,
    input  logic             inc_h,
    input  logic             inc_m,
    output logic [BCD_W-1:0] b0,
    output logic [BCD_W-1:0] b1,
    output logic [BCD_W-1:0] b2,
    output logic [BCD_W-1:0] b3,
    output logic             seg,
    output logic             minuto
);

    localparam int            PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);

    logic [PW-1:0]    presc;
    logic [SEG_W-1:0] segs;
    logic             prev_h, prev_m;
    logic             tick, fin_seg;
    logic             edge_h, edge_m;
    logic             en_min, en_hora;
    logic             carry_min;
    logic             unused_dia;    // day rollover has no output

    always_comb begin
        // Set mode gates the tick, so ajuste rising on a tick cycle wins.
        tick    = !ajuste && (presc >= PRE_TC);
        fin_seg = tick && (segs == SEG_MAX);
        edge_h  = inc_h && !prev_h;
        edge_m  = inc_m && !prev_m;
        // In set mode the minute wrap must not reach the hours.
        en_min  = ajuste ? edge_m : fin_seg;
        en_hora = ajuste ? edge_h : carry_min;
    end

    always_ff @(posedge reloj1 or negedge reset_n) begin
        if (!reset_n) begin
            presc  <= '0;
            segs   <= '0;
            seg    <= 1'b0;
            minuto <= 1'b0;
            prev_h <= 1'b0;
            prev_m <= 1'b0;
        end else begin
            // Edge registers follow the buttons in both modes.
            prev_h <= inc_h;
            prev_m <= inc_m;
            if (ajuste) begin
                presc  <= '0;
                segs   <= '0;
                seg    <= 1'b0;
                minuto <= 1'b0;
            end else begin
                seg    <= tick;
                minuto <= fin_seg;
                if (tick) begin
                    presc <= '0;
                    segs  <= (segs >= SEG_MAX) ? '0 : segs + 6'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    contador_bcd2 #(
        .DEC_MAX (MIN_D_MAX),
        .UNI_TOP (MIN_U_MAX)
    ) u_min (
        .reloj1  (reloj1),
        .reset_n (reset_n),
        .clr     (1'b0),
        .en      (en_min),
        .uni     (b0),
        .dec     (b1),
        .carry   (carry_min)
    );

    contador_bcd2 #(
        .DEC_MAX (HORA_D_MAX),
        .UNI_TOP (HORA_U_MAX_23)
    ) u_hora (
        .reloj1  (reloj1),
        .reset_n (reset_n),
        .clr     (1'b0),
        .en      (en_hora),
        .uni     (b2),
        .dec     (b3),
        .carry   (unused_dia)
    );

endmodule

// File: tb/tb_reloj_hora.sv
// Directed bench for reloj_hora with CLK_HZ = 4.
module tb_reloj_hora;

    logic       reloj1, reset_n, ajuste, inc_h, inc_m;
    logic [3:0] b0, b1, b2, b3;
    logic       seg, minuto;
    logic [15:0] hhmm;

    int total = 0;
    int bad   = 0;
    int seg_cnt = 0;
    int min_cnt = 0;
    int s0;

    reloj_hora #(.CLK_HZ(4)) dut (
        .reloj1  (reloj1),
        .reset_n (reset_n),
        .ajuste  (ajuste),
        .inc_h   (inc_h),
        .inc_m   (inc_m),
        .b0      (b0),
        .b1      (b1),
        .b2      (b2),
        .b3      (b3),
        .seg     (seg),
        .minuto  (minuto)
    );

    assign hhmm = {b3, b2, b1, b0};

    initial begin
        reloj1 = 1'b0;
        forever #5 reloj1 = ~reloj1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; samples on the falling edge and tallies pulses.
    task automatic cyc();
        @(negedge reloj1);
        if (seg)    seg_cnt++;
        if (minuto) min_cnt++;
    endtask

    task automatic press_m(input int n);
        for (int i = 0; i < n; i++) begin
            inc_m = 1'b1; cyc();
            inc_m = 1'b0; cyc();
        end
    endtask

    task automatic press_h(input int n);
        for (int i = 0; i < n; i++) begin
            inc_h = 1'b1; cyc();
            inc_h = 1'b0; cyc();
        end
    endtask

    // Leave set mode (prescaler at 0) and run one full minute.
    task automatic run_min(input string tag, input logic [15:0] t0, input logic [15:0] t1);
        int sc, mc;
        sc = seg_cnt;
        mc = min_cnt;
        ajuste = 1'b0;
        for (int i = 1; i <= 240; i++) begin
            cyc();
            if (i == 3) chk({tag, "_seg_c3"}, seg, 1'b0);
            if (i == 4) chk({tag, "_seg_c4"}, seg, 1'b1);
            if (i == 239) begin
                chk({tag, "_t239"}, hhmm, t0);
                chk({tag, "_min239"}, minuto, 1'b0);
            end
        end
        chk({tag, "_min240"}, minuto, 1'b1);
        chk({tag, "_seg240"}, seg, 1'b1);
        chk({tag, "_t240"}, hhmm, t1);
        chk({tag, "_nseg"}, seg_cnt - sc, 60);
        chk({tag, "_nmin"}, min_cnt - mc, 1);
    endtask

    initial begin
        reset_n = 1'b0; ajuste = 1'b0; inc_h = 1'b0; inc_m = 1'b0;
        repeat (3) cyc();
        chk("rst_time", hhmm, 16'h0000);
        chk("rst_seg", seg, 1'b0);
        chk("rst_minuto", minuto, 1'b0);

        // Free run from reset release: first seg on cycle 4, minute on 240.
        reset_n = 1'b1;
        run_min("free", 16'h0000, 16'h0001);

        // Reset while seg is high and time is 00:01: clears immediately.
        #2 reset_n = 1'b0;
        #1;
        chk("async_time", hhmm, 16'h0000);
        chk("async_seg", seg, 1'b0);
        chk("async_minuto", minuto, 1'b0);
        ajuste = 1'b1;
        cyc(); cyc();
        reset_n = 1'b1;

        // Set mode.
        s0 = seg_cnt;
        press_m(61);
        chk("set_m61", hhmm, 16'h0001);
        press_h(25);
        chk("set_h25", hhmm, 16'h0101);
        inc_m = 1'b1;
        repeat (10) cyc();
        inc_m = 1'b0;
        cyc();
        chk("held_m", hhmm, 16'h0102);
        chk("set_noseg", seg_cnt - s0, 0);

        // 09:59 -> 10:00
        press_h(8);
        press_m(57);
        chk("set_0959", hhmm, 16'h0959);
        run_min("h09", 16'h0959, 16'h1000);

        // 19:59 -> 20:00
        ajuste = 1'b1;
        press_h(9);
        press_m(59);
        chk("set_1959", hhmm, 16'h1959);
        run_min("h19", 16'h1959, 16'h2000);

        // Simultaneous edges at 23:59: minutes wrap without carry, hours wrap.
        ajuste = 1'b1;
        press_h(3);
        press_m(59);
        chk("set_2359", hhmm, 16'h2359);
        inc_h = 1'b1; inc_m = 1'b1;
        cyc();
        inc_h = 1'b0; inc_m = 1'b0;
        cyc();
        chk("simul", hhmm, 16'h0000);

        // Day wrap.
        press_h(23);
        press_m(59);
        chk("set_2359b", hhmm, 16'h2359);
        run_min("day", 16'h2359, 16'h0000);

        // ajuste rising on the tick cycle.
        ajuste = 1'b1;
        cyc(); cyc();
        ajuste = 1'b0;
        cyc(); cyc(); cyc();
        s0 = seg_cnt;
        ajuste = 1'b1;
        cyc();
        chk("tick_aj_seg", seg, 1'b0);
        repeat (6) cyc();
        chk("tick_aj_nseg", seg_cnt - s0, 0);
        chk("tick_aj_time", hhmm, 16'h0000);

        // Buttons ignored in run mode.
        ajuste = 1'b0;
        press_h(3);
        press_m(3);
        chk("run_btn", hhmm, 16'h0000);

        // Enter set mode mid-count, leave again: first seg 4 cycles later.
        cyc();
        ajuste = 1'b1;
        cyc(); cyc();
        ajuste = 1'b0;
        cyc(); cyc(); cyc();
        chk("exit_seg_c3", seg, 1'b0);
        cyc();
        chk("exit_seg_c4", seg, 1'b1);
        chk("exit_time", hhmm, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reloj_hora.md
# reloj_hora

Time-of-day generator for the alarm clock: divides the FPGA clock to a 1 Hz tick and keeps a 24-hour HH:MM time in four BCD digits. It drives the clock-side digit inputs of the alarm comparator and the display. Time is set with two hour/minute increment buttons while a set-mode switch is held.

## Interface
- CLK_HZ, 50_000_000: `reloj1` cycles per second; benches override it with a small value.
- reloj1  in  1  FPGA clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ajuste  in  1  set-mode level, already debounced; high = setting time.
- inc_h  in  1  hour-increment button level, already debounced.
- inc_m  in  1  minute-increment button level, already debounced.
- b0  out  4  BCD units of minutes.
- b1  out  4  BCD tens of minutes.
- b2  out  4  BCD units of hours.
- b3  out  4  BCD tens of hours.
- seg  out  1  one-cycle pulse per elapsed second, run mode only.
- minuto  out  1  one-cycle pulse when the minute advances automatically.

## Operation
- Reset (async, reset_n low) forces the following, and holds them while reset_n is low:
  - time 00:00:00;
  - prescaler = 0;
  - seg = 0, minuto = 0;
  - button edge registers = 0.
- Prescaler counts 0..CLK_HZ-1. At terminal count it wraps to 0 and raises an internal tick for one cycle.
- Seconds counter (internal, 0..59, binary or BCD) advances on each tick. At 59 plus a tick it wraps to 0 and carries into minutes.
- Minutes:
  - b0 counts 0..9; its wrap carries to b1.
  - b1 counts 0..5; 59 plus a carry gives 00 and carries into hours.
- Hours:
  - b2 counts 0..9 while b3 < 2, and 0..3 while b3 = 2.
  - 23 plus a carry gives 00 (day wrap; no output for it).
- Digits never take values outside these ranges. Any illegal combination reachable only by fault is corrected to 0 on the next update.
- Run mode (ajuste = 0): timekeeping as above. inc_h and inc_m are ignored, but their edge registers keep tracking.
- Set mode (ajuste = 1):
  - prescaler and seconds are held at 0; seg and minuto stay 0;
  - each rising edge of inc_m adds one minute, wrapping 59 to 00 with no carry into hours;
  - each rising edge of inc_h adds one hour, wrapping 23 to 00;
  - rising edges of inc_m and inc_h in the same cycle both apply.
- Button rising edge = current level high while the registered previous level is low. A held button counts once.
- Leaving set mode: the prescaler restarts from 0, and the first seg pulse comes CLK_HZ cycles after the first cycle with ajuste = 0.

## Timing
- All outputs are registered.
- Digit update latency: 1 cycle after the tick or button edge.
  - Tick latency: the digits change on the same edge that asserts seg (and minuto when it fires).
  - Button latency: the digits change on the edge following the first cycle in which the button is high.
- seg and minuto are high for exactly one reloj1 cycle. minuto coincides with the seg pulse that completes second 59.
- ajuste rising in the same cycle as a tick: set mode wins; no advance and no pulse.
- Reset mid-count: outputs clear immediately (asynchronously). Operation resumes on the first reloj1 edge after reset_n rises.

## Structure
- Package reloj_pkg holds:
  - BCD_W = 4;
  - digit limits MIN_U_MAX = 9, MIN_D_MAX = 5, HORA_D_MAX = 2, HORA_U_MAX_23 = 3;
  - SEG_MAX = 59.
- One sub-module, contador_bcd2: a two-digit BCD counter with a parameterised terminal value (59 or 23), an enable input, a carry-out and a synchronous clear. It is instantiated for minutes and hours.
- The prescaler, seconds counter, edge detectors and mode muxing live in reloj_hora.

## Test plan
All scenarios use CLK_HZ = 4.
- Reset: assert reset_n = 0 mid-count → b3..b0 = 0,0,0,0 and seg = minuto = 0 immediately; the first seg pulse comes 4 cycles after release.
- Free run: 60 seconds from 00:00:00 → minuto pulses once with seg on cycle 240; digits read 00:01.
- Day wrap: set 23:59, run 60 s → digits read 00:00 with one minuto pulse; hour-carry boundaries at 09:59 → 10:00 and 19:59 → 20:00 are checked.
- Set mode: ajuste = 1, press inc_m 61 times from 00:00 → 00:01 and hours unchanged. Press inc_h 25 times → 01:01. A button held for 10 cycles counts once; no seg pulses occur.
- Simultaneous events: inc_h and inc_m rise in the same cycle from 23:59 → 00:00. ajuste rises on the tick cycle → no seg pulse and no advance.
- Run-mode buttons: inc_h/inc_m pulses with ajuste = 0 leave the digits unchanged. Leaving set mode mid-count gives the first seg exactly 4 cycles later.
